// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the select of a shared 4:1 mux.
// A grant is held for up to MAX_BEATS beats or until its owner stops requesting.
module mux4_rr_sched #(
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       req_i,
  input  logic             ready_i,
  output logic [3:0]       gnt_o,
  output logic [1:0]       sel_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BEATS - 1);

  state_t           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic       w_busy;
  logic       w_valid;
  logic       w_beat;
  logic       w_rel;
  logic       w_arb;
  logic       w_found;
  logic [1:0] w_win;

  assign w_busy  = (r_state == GRANT);
  assign w_valid = w_busy & req_i[r_sel];
  assign w_beat  = w_valid & ready_i;
  assign w_rel   = w_busy &
                   (~req_i[r_sel] | (w_beat & (r_cnt == LAST)));
  assign w_arb   = ~w_busy | w_rel;

  // Scan from the pointer upward; first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && req_i[r_ptr + 2'(i)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else if (w_arb) begin
      r_cnt <= '0;
      if (w_found) begin
        r_state <= GRANT;
        r_gnt   <= 4'b0001 << w_win;
        r_sel   <= w_win;
        r_ptr   <= w_win + 2'd1;
      end else begin
        r_state <= IDLE;
        r_gnt   <= '0;
      end
    end else if (w_beat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign gnt_o      = r_gnt;
  assign sel_o      = r_sel;
  assign valid_o    = w_valid;
  assign busy_o     = w_busy;
  assign beat_cnt_o = r_cnt;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Bench for mux4_rr_sched: two instances (MAX_BEATS 4 and 2) on shared
// stimulus, checked each cycle against an integer-level behavioural model.
module tb_mux4_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       rdy;

  logic [3:0] gnt4, gnt2;
  logic [1:0] sel4, sel2;
  logic       v4, v2, b4, b2;
  logic [2:0] cnt4;
  logic [1:0] cnt2;

  int vectors = 0;
  int errors  = 0;

  int mb[2] = '{4, 2};
  int m_own[2];
  int m_cnt[2];
  int m_ptr[2];
  int m_sel[2];

  always #5 clk = ~clk;

  mux4_rr_sched #(.MAX_BEATS(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ready_i(rdy),
    .gnt_o(gnt4), .sel_o(sel4), .valid_o(v4), .busy_o(b4),
    .beat_cnt_o(cnt4)
  );

  mux4_rr_sched #(.MAX_BEATS(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ready_i(rdy),
    .gnt_o(gnt2), .sel_o(sel2), .valid_o(v2), .busy_o(b2),
    .beat_cnt_o(cnt2)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1;
      m_cnt[m] = 0;
      m_ptr[m] = 0;
      m_sel[m] = 0;
    end
  endtask

  // Advance the model by one clock edge given the inputs seen before it.
  task automatic m_step(input logic [3:0] r, input logic rd);
    for (int m = 0; m < 2; m++) begin
      bit busy, val, rel;
      int w;
      busy = (m_own[m] >= 0);
      val  = busy ? r[m_own[m]] : 1'b0;
      rel  = busy && (!val || (rd && m_cnt[m] == mb[m] - 1));
      if (!busy || rel) begin
        w = -1;
        for (int i = 0; i < 4; i++)
          if (w < 0 && r[(m_ptr[m] + i) % 4]) w = (m_ptr[m] + i) % 4;
        m_cnt[m] = 0;
        m_own[m] = w;
        if (w >= 0) begin
          m_sel[m] = w;
          m_ptr[m] = (w + 1) % 4;
        end
      end else if (val && rd) begin
        m_cnt[m]++;
      end
    end
  endtask

  function automatic logic [3:0] m_gnt(input int m);
    return (m_own[m] < 0) ? 4'b0000 : 4'(1 << m_own[m]);
  endfunction

  function automatic logic m_val(input int m);
    return (m_own[m] < 0) ? 1'b0 : req[m_own[m]];
  endfunction

  task automatic compare();
    chk("gnt4", gnt4, m_gnt(0));
    chk("sel4", sel4, m_sel[0]);
    chk("busy4", b4, m_own[0] >= 0);
    chk("valid4", v4, m_val(0));
    chk("cnt4", cnt4, m_cnt[0]);
    chk("gnt2", gnt2, m_gnt(1));
    chk("sel2", sel2, m_sel[1]);
    chk("busy2", b2, m_own[1] >= 0);
    chk("valid2", v2, m_val(1));
    chk("cnt2", cnt2, m_cnt[1]);
  endtask

  task automatic step(input logic [3:0] r, input logic rd);
    req = r;
    rdy = rd;
    #1;
    compare();
    @(posedge clk);
    m_step(r, rd);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rdy   = 1'b0;
    rst_n = 1'b0;
    #1;
    m_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_step(4'b0000, 1'b0);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    rdy   = 1'b0;
    #2;
    m_reset();
    chk("rst gnt4", gnt4, 0);
    chk("rst busy4", b4, 0);
    chk("rst sel4", sel4, 0);
    chk("rst cnt4", cnt4, 0);
    do_reset();

    // Single requester, 4 beats then regrant to itself.
    step(4'b0100, 1'b1);
    chk("t1 gnt", gnt4, 4'b0100);
    chk("t1 sel", sel4, 2);
    chk("t1 cnt0", cnt4, 0);
    step(4'b0100, 1'b1);
    chk("t1 cnt1", cnt4, 1);
    step(4'b0100, 1'b1);
    chk("t1 cnt2", cnt4, 2);
    step(4'b0100, 1'b1);
    chk("t1 cnt3", cnt4, 3);
    step(4'b0100, 1'b1);
    chk("t1 regrant", gnt4, 4'b0100);
    chk("t1 cnt rst", cnt4, 0);

    // Full contention on the MAX_BEATS=2 instance.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(4'b1111, 1'b1);
      chk("t2 sel", sel2, ((k - 1) / 2) % 4);
      chk("t2 busy", b2, 1);
    end

    // Early drop by owner 1 while 3 waits.
    do_reset();
    step(4'b0010, 1'b1);
    step(4'b1010, 1'b1);
    chk("t3 cnt", cnt4, 1);
    req = 4'b1000;
    #1;
    chk("t3 valid", v4, 0);
    step(4'b1000, 1'b1);
    chk("t3 gnt", gnt4, 4'b1000);
    chk("t3 sel", sel4, 3);
    chk("t3 cnt", cnt4, 0);

    // Backpressure holds the beat count.
    do_reset();
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    for (int k = 0; k < 10; k++) step(4'b0001, 1'b0);
    chk("t4 cnt hold", cnt4, 1);
    chk("t4 gnt hold", gnt4, 4'b0001);
    chk("t4 valid", v4, 1);
    step(4'b0001, 1'b1);
    chk("t4 resume", cnt4, 2);

    // Async reset mid-grant, then pointer restarts at 0.
    do_reset();
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 gnt", gnt4, 0);
    chk("t5 busy", b4, 0);
    chk("t5 cnt", cnt4, 0);
    m_reset();
    req = 4'b1010;
    rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_step(4'b1010, 1'b1);
    #1;
    chk("t5 regrant", gnt4, 4'b0010);

    // Idle return keeps sel, then a fresh request.
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b0);
    chk("t6 busy", b4, 0);
    chk("t6 gnt", gnt4, 0);
    chk("t6 sel", sel4, 1);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    chk("t6 gnt new", gnt4, 4'b0001);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] r;
      if ($urandom_range(0, 199) == 0) do_reset();
      r = 4'($urandom);
      if ($urandom_range(0, 3) != 0) r = r | (m_own[0] >= 0 ? 4'(1 << m_own[0]) : 4'b0);
      step(r, 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares one 4:1 multiplexer between four requesters.
- Generates the 2-bit `sel_o` for the mux, a one-hot grant back to the requesters, and a `valid_o` toward the downstream consumer.
- A grant is held for consecutive beats until the owner drops its request or a beat limit is reached, so no requester can starve the others.

Parameters:
- MAX_BEATS, 4, maximum transfer beats per grant; legal range 1..256.
- CNT_W, $clog2(MAX_BEATS+1), width of the beat counter; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  4  request per input; bit k is requester k (mux input xk).
- ready_i  input  1  downstream accepts the muxed data this cycle.
- gnt_o  output  4  one-hot grant, registered; all zero when idle.
- sel_o  output  2  mux select, registered; equals the index of the set `gnt_o` bit; holds its last value when idle.
- valid_o  output  1  muxed data valid; equals busy_o AND req_i[sel_o] (combinational).
- busy_o  output  1  high in state GRANT.
- beat_cnt_o  output  CNT_W  beats completed in the current grant.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, gnt_o=0, sel_o=0, busy_o=0, beat_cnt_o=0, rr pointer=0 (req0 highest priority). Asserting reset mid-grant aborts the grant immediately with no completion beat.
- States: IDLE, GRANT.
- Arbitration:
  - Priority order starts at rr pointer: ptr, ptr+1, ... mod 4.
  - First set `req_i` bit in that order wins.
  - On each new grant, ptr <= winner+1 mod 4.
- IDLE:
  - If `req_i` != 0 in cycle N, then in cycle N+1: state=GRANT, gnt_o=onehot(winner), sel_o=winner, beat_cnt_o=0.
  - Latency from first request to grant is 1 cycle.
- GRANT:
  - Beat = valid_o && ready_i.
  - Each beat increments beat_cnt_o, except on a release cycle.
- Release condition, evaluated each GRANT cycle:
  - (a) req_i[sel_o]=0, or
  - (b) a beat occurs with beat_cnt_o = MAX_BEATS-1.
- On release (back-to-back, no bubble):
  - Arbitrate among req_i in the same cycle, starting from ptr (= owner+1). The owner is therefore eligible only last.
  - If there is a winner, the next cycle has a new grant with beat_cnt_o=0.
  - If there is no winner, the next cycle is IDLE with gnt_o=0, busy_o=0, beat_cnt_o=0.
- Requester k holding req with no ready_i: the grant stays indefinitely, valid_o=1, beat_cnt_o is frozen. There is no timeout.
- Requests from non-owners never affect the current grant. They are only sampled at IDLE or release cycles.
- MAX_BEATS=1: every beat releases; requesters then rotate each beat when all are active.
- Dropping req_i[sel_o] while ready_i=1 is not a beat (valid_o=0). The release follows rule (a).
- gnt_o is always one-hot or zero. sel_o never changes while busy_o=1 except at a release/regrant edge.
- Assertions for verification:
  - $onehot0(gnt_o)
  - busy_o == (gnt_o != 0)
  - beat_cnt_o < MAX_BEATS

Test Plan:
- Single requester, MAX_BEATS=4: reset, then req_i=4'b0100, ready_i=1 held.
  - Cycle 1: gnt_o=0100, sel_o=2.
  - Beats counted 0,1,2,3, then release.
  - req still high → regrant to 2 next cycle (only requester), beat_cnt_o=0.
- Full contention, MAX_BEATS=2: req_i=4'b1111, ready_i=1.
  - Grant sequence 0,1,2,3,0 with each grant lasting exactly 2 beats.
  - No idle cycles between grants.
- Early drop: requester 1 granted, lowers req_i[1] after 1 beat while req_i[3]=1.
  - That cycle valid_o=0.
  - Next cycle gnt_o=1000, sel_o=3, beat_cnt_o=0.
- Backpressure: owner 0, ready_i=0 for 10 cycles.
  - valid_o=1, beat_cnt_o stays at its value, gnt_o unchanged.
  - ready_i=1 resumes counting from that value.
- Async reset mid-grant: pull rst_ni low between clock edges during beat 2.
  - gnt_o=0, busy_o=0, beat_cnt_o=0 immediately without a clock.
  - After release, req_i=4'b1010 → gnt_o=0010 (ptr reset to 0).
- Idle return: the single requester drops its request.
  - Next cycle busy_o=0, gnt_o=0, sel_o keeps its last value.
  - A new req_i=4'b0001 one cycle later → gnt_o=0001 the following cycle.
